// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues icache reads and loads the IF/ID latch.
// A redirect that arrives while the fetch cannot complete is parked until the next ihit.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        stallPC,
  input  logic        ifidFreeze,
  input  logic        ifidFlush,
  input  logic        jumpBranch,
  input  logic [31:0] pcTarget,
  input  logic        dmemBusy,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcPlus4
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_aligned;

  assign pc_plus4    = pc_q + 32'd4;
  assign tgt_aligned = {pcTarget[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;

    if (state_q == FETCH) begin
      if (halt) begin
        // halt beats any redirect on the same edge; everything freezes from here on
        state_d = HALTED;
      end else if (dmemBusy) begin
        if (jumpBranch) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = tgt_aligned;
        end
      end else if (jumpBranch) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = 32'd0;
        ifid_pc4_d   = 32'd0;
        if (ihit) begin
          pc_d         = tgt_aligned;
          redir_pend_d = 1'b0;
        end else begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = tgt_aligned;
        end
      end else begin
        if (ifidFreeze) begin
          ifid_valid_d = ifid_valid_q;
        end else if (ifidFlush || (ihit && redir_pend_q)) begin
          // a hit while a redirect is parked returns a wrong-path word: drop it
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'd0;
          ifid_pc4_d   = 32'd0;
        end else if (ihit && !stallPC) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = imemload;
          ifid_pc4_d   = pc_plus4;
        end

        if (!stallPC && ihit) begin
          pc_d         = redir_pend_q ? redir_tgt_q : pc_plus4;
          redir_pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imemREN      = (state_q == FETCH) && !RST;
  assign imemaddr     = pc_q;
  assign pc           = pc_q;
  assign ifid_valid   = ifid_valid_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pcPlus4 = ifid_pc4_q;

endmodule
